// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for the programmable-modulus J/K counter.
interface jk_mod_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             tc;
    logic             wrap;
    logic             load_err;

    modport master (
        output en, up, load, load_val,
        input  q, j_vec, k_vec, tc, wrap, load_err
    );

    modport slave (
        input  en, up, load, load_val,
        output q, j_vec, k_vec, tc, wrap, load_err
    );
endinterface

// File: rtl/jk_mod_counter.sv
// Programmable-modulus up/down counter built from J/K flip-flop cells.
// The counter computes the next count each cycle and drives per-bit J/K in
// toggle form; only the wrap and load_err pulses live outside the cells.

// Single J/K cell with synchronous active-low reset (Q resets to 0).
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);
    logic q_d;
    logic q_q;

    // Classic J/K next-state table: hold, reset, set, toggle.
    always_comb begin
        q_d = q_q;
        unique case ({j, k})
            2'b00:   q_d = q_q;
            2'b01:   q_d = 1'b0;
            2'b10:   q_d = 1'b1;
            default: q_d = ~q_q;
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) q_q <= 1'b0;
        else      q_q <= q_d;
    end

    assign q = q_q;
endmodule

module jk_mod_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    jk_mod_counter_if.slave  bus
);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] excite;
    logic             at_max;
    logic             at_zero;
    logic             illegal;
    logic             wrap_d;
    logic             wrap_q;
    logic             load_err_d;
    logic             load_err_q;

    // One J/K cell per count bit; J and K are tied together for toggle form.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff u_cell (
            .clk (clk),
            .rst (rst),
            .j   (excite[i]),
            .k   (excite[i]),
            .q   (cnt_q[i])
        );
    end

    // Decode the current count for wrap points and terminal count.
    always_comb begin
        at_max  = (cnt_q == MAX_V);
        at_zero = (cnt_q == '0);
        illegal = ({1'b0, cnt_q} >= MOD_W);
    end

    // Next count in priority order: load, count up/down, hold.
    // An out-of-range count is treated as a wrap point in either direction.
    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (bus.load) begin
            if ({1'b0, bus.load_val} < MOD_W) begin
                cnt_d = bus.load_val;
            end else begin
                cnt_d      = '0;
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max || illegal) begin
                    cnt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE_V;
                end
            end else begin
                if (at_zero || illegal) begin
                    cnt_d  = MAX_V;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE_V;
                end
            end
        end
    end

    // Bits that change toggle (J=K=1); unchanged bits hold (J=K=0).
    always_comb begin
        excite = cnt_q ^ cnt_d;
    end

    // One-cycle status pulses, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.q        = cnt_q;
    assign bus.j_vec    = excite;
    assign bus.k_vec    = excite;
    assign bus.tc       = bus.up ? at_max : at_zero;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter at MOD=10 and MOD=16 (WIDTH=4).
module tb_jk_mod_counter;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    jk_mod_counter_if #(.WIDTH(4)) b10 ();
    jk_mod_counter_if #(.WIDTH(4)) b16 ();

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut10 (
        .clk (clk),
        .rst (rst),
        .bus (b10)
    );

    jk_mod_counter #(.WIDTH(4), .MOD(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (b16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        b10.en = 1'b0; b10.up = 1'b1; b10.load = 1'b1; b10.load_val = 4'd5;
        b16.en = 1'b0; b16.up = 1'b1; b16.load = 1'b0; b16.load_val = 4'd0;

        // Reset overrides a pending load.
        step(); step();
        chk("rst_q", b10.q, 0);
        chk("rst_wrap", b10.wrap, 0);
        chk("rst_lerr", b10.load_err, 0);
        chk("rst_q16", b16.q, 0);

        // Count up 0..9,0,1,2.
        rst = 1'b1; b10.load = 1'b0; b10.en = 1'b1; b10.up = 1'b1;
        #1;
        chk("up_j0", b10.j_vec, 4'b0001);
        chk("up_tc0", b10.tc, 0);
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("up_q", b10.q, i % 10);
            chk("up_wrap", b10.wrap, (i == 10) ? 1 : 0);
            chk("up_tc", b10.tc, (i == 9) ? 1 : 0);
            if (i == 9) begin
                chk("up_j9", b10.j_vec, 4'b1001);
                chk("up_k9", b10.k_vec, 4'b1001);
            end
        end

        // Load 1 then count down 0,9,8.
        b10.load = 1'b1; b10.load_val = 4'd1; b10.en = 1'b0;
        step();
        chk("ld1_q", b10.q, 1);
        b10.load = 1'b0; b10.en = 1'b1; b10.up = 1'b0;
        step();
        chk("dn_q0", b10.q, 0);
        chk("dn_wrap0", b10.wrap, 0);
        chk("dn_tc0", b10.tc, 1);
        chk("dn_j0", b10.j_vec, 4'b1001);
        chk("dn_k0", b10.k_vec, 4'b1001);
        step();
        chk("dn_q9", b10.q, 9);
        chk("dn_wrap9", b10.wrap, 1);
        chk("dn_tc9", b10.tc, 0);
        step();
        chk("dn_q8", b10.q, 8);
        chk("dn_wrap8", b10.wrap, 0);

        // Out-of-range load clamps to 0 and flags load_err.
        b10.en = 1'b0; b10.up = 1'b1; b10.load = 1'b1; b10.load_val = 4'd12;
        step();
        chk("lerr_q", b10.q, 0);
        chk("lerr_flag", b10.load_err, 1);
        chk("lerr_wrap", b10.wrap, 0);
        b10.load_val = 4'd7; b10.en = 1'b1;
        step();
        chk("ld7_q", b10.q, 7);
        chk("ld7_lerr", b10.load_err, 0);
        chk("ld7_wrap", b10.wrap, 0);

        // Load to 0 from 9 with en: load wins, no wrap.
        b10.en = 1'b0; b10.load_val = 4'd9;
        step();
        chk("ld9_q", b10.q, 9);
        b10.en = 1'b1; b10.load_val = 4'd0;
        step();
        chk("ld0_q", b10.q, 0);
        chk("ld0_wrap", b10.wrap, 0);

        // Hold at 6, then alternate direction.
        b10.en = 1'b0; b10.load_val = 4'd6;
        step();
        b10.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_q", b10.q, 6);
            chk("hold_j", b10.j_vec, 0);
            chk("hold_k", b10.k_vec, 0);
        end
        b10.en = 1'b1; b10.up = 1'b1;
        step(); chk("alt_q7a", b10.q, 7);
        b10.up = 1'b0;
        step(); chk("alt_q6a", b10.q, 6);
        b10.up = 1'b1;
        step(); chk("alt_q7b", b10.q, 7);
        b10.up = 1'b0;
        step(); chk("alt_q6b", b10.q, 6);

        // Reset mid-count at q=4: no wrap, counting resumes from 0.
        b10.en = 1'b0; b10.load = 1'b1; b10.load_val = 4'd4;
        step();
        chk("mid_q4", b10.q, 4);
        b10.load = 1'b0; b10.en = 1'b1; b10.up = 1'b1; rst = 1'b0;
        step();
        chk("mid_rst_q", b10.q, 0);
        chk("mid_rst_wrap", b10.wrap, 0);
        rst = 1'b1;
        step();
        chk("mid_resume_q", b10.q, 1);
        chk("mid_resume_wrap", b10.wrap, 0);
        b10.en = 1'b0;

        // Modulus 16: natural binary wrap up and down, full-range load is legal.
        b16.en = 1'b1; b16.up = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            step();
            chk("m16_q", b16.q, i % 16);
            chk("m16_wrap", b16.wrap, (i == 16) ? 1 : 0);
            chk("m16_tc", b16.tc, (i == 15) ? 1 : 0);
        end
        b16.up = 1'b0;
        step();
        chk("m16_dn_q", b16.q, 0);
        step();
        chk("m16_dn_q15", b16.q, 15);
        chk("m16_dn_wrap", b16.wrap, 1);
        b16.en = 1'b0; b16.load = 1'b1; b16.load_val = 4'd15;
        step();
        chk("m16_ld15_q", b16.q, 15);
        chk("m16_ld15_lerr", b16.load_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
